// File: rtl/key_ascii_tracker_pkg.sv
// Shared definitions for the PS/2 scan-code-set-2 to ASCII tracker:
// prefix FSM states, event classes and the scan codes the design reacts to.
package key_ascii_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } prefix_state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_MAKE,
        EV_BREAK,
        EV_EXTENDED
    } key_event_t;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;

    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    localparam logic [7:0] CODE_SPACE  = 8'h29;
    localparam logic [7:0] CODE_ENTER  = 8'h5A;
    localparam logic [7:0] CODE_BKSP   = 8'h66;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ENTER = 8'h0D;
    localparam logic [7:0] ASCII_BKSP  = 8'h08;

    // Distance between a lowercase letter and its uppercase form.
    localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational scan-code-set-2 make code to ASCII lookup; hit marks a
// mapped code, upper selects uppercase for letters only.
module scancode_to_ascii
    import key_ascii_tracker_pkg::*;
(
    input  logic [7:0] code,
    input  logic       upper,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [7:0] base;
    logic       letter;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        base   = 8'h00;
        letter = 1'b0;
        hit    = 1'b1;
        unique case (code)
            8'h1C: begin base = 8'h61; letter = 1'b1; end
            8'h32: begin base = 8'h62; letter = 1'b1; end
            8'h21: begin base = 8'h63; letter = 1'b1; end
            8'h23: begin base = 8'h64; letter = 1'b1; end
            8'h24: begin base = 8'h65; letter = 1'b1; end
            8'h2B: begin base = 8'h66; letter = 1'b1; end
            8'h34: begin base = 8'h67; letter = 1'b1; end
            8'h33: begin base = 8'h68; letter = 1'b1; end
            8'h43: begin base = 8'h69; letter = 1'b1; end
            8'h3B: begin base = 8'h6A; letter = 1'b1; end
            8'h42: begin base = 8'h6B; letter = 1'b1; end
            8'h4B: begin base = 8'h6C; letter = 1'b1; end
            8'h3A: begin base = 8'h6D; letter = 1'b1; end
            8'h31: begin base = 8'h6E; letter = 1'b1; end
            8'h44: begin base = 8'h6F; letter = 1'b1; end
            8'h4D: begin base = 8'h70; letter = 1'b1; end
            8'h15: begin base = 8'h71; letter = 1'b1; end
            8'h2D: begin base = 8'h72; letter = 1'b1; end
            8'h1B: begin base = 8'h73; letter = 1'b1; end
            8'h2C: begin base = 8'h74; letter = 1'b1; end
            8'h3C: begin base = 8'h75; letter = 1'b1; end
            8'h2A: begin base = 8'h76; letter = 1'b1; end
            8'h1D: begin base = 8'h77; letter = 1'b1; end
            8'h22: begin base = 8'h78; letter = 1'b1; end
            8'h35: begin base = 8'h79; letter = 1'b1; end
            8'h1A: begin base = 8'h7A; letter = 1'b1; end
            8'h45: base = 8'h30;
            8'h16: base = 8'h31;
            8'h1E: base = 8'h32;
            8'h26: base = 8'h33;
            8'h25: base = 8'h34;
            8'h2E: base = 8'h35;
            8'h36: base = 8'h36;
            8'h3D: base = 8'h37;
            8'h3E: base = 8'h38;
            8'h46: base = 8'h39;
            CODE_SPACE: base = ASCII_SPACE;
            CODE_ENTER: base = ASCII_ENTER;
            CODE_BKSP:  base = ASCII_BKSP;
            default:    hit  = 1'b0;
        endcase

        ascii = (letter && upper) ? base - CASE_OFFSET : base;
    end

endmodule

// File: rtl/key_ascii_tracker.sv
// Tracks PS/2 set-2 key events: E0/F0 prefix FSM, shift/caps modifiers and
// a two-deep history of typed ASCII characters.
module key_ascii_tracker
    import key_ascii_tracker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic [7:0] ascii1,
    output logic [7:0] ascii2,
    output logic       new_char,
    output logic       shift_active,
    output logic       caps_on
);

    prefix_state_t state, state_next;
    key_event_t    key_event;

    logic       lshift_held;
    logic       rshift_held;
    logic       caps_held;
    logic [7:0] lookup_ascii;
    logic       lookup_hit;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        key_event  = EV_NONE;
        if (byte_valid) begin
            state_next = ST_IDLE;
            unique case (state)
                ST_IDLE: begin
                    if (byte_in == CODE_EXT) begin
                        state_next = ST_EXT;
                    end else if (byte_in == CODE_BRK) begin
                        state_next = ST_BRK;
                    end else begin
                        key_event = EV_MAKE;
                    end
                end
                ST_EXT: begin
                    if (byte_in == CODE_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        key_event = EV_EXTENDED;
                    end
                end
                ST_BRK:     key_event = EV_BREAK;
                ST_EXT_BRK: key_event = EV_EXTENDED;
            endcase
        end
    end

    // Case selection uses the modifier state as it was before this byte.
    scancode_to_ascii u_lookup (
        .code  (byte_in),
        .upper (shift_active ^ caps_on),
        .ascii (lookup_ascii),
        .hit   (lookup_hit)
    );

    assign shift_active = lshift_held | rshift_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            ascii1      <= 8'h00;
            ascii2      <= 8'h00;
            new_char    <= 1'b0;
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            caps_held   <= 1'b0;
            caps_on     <= 1'b0;
        end else begin
            new_char <= 1'b0;
            unique case (key_event)
                EV_MAKE: begin
                    if (byte_in == CODE_LSHIFT) lshift_held <= 1'b1;
                    if (byte_in == CODE_RSHIFT) rshift_held <= 1'b1;
                    if (byte_in == CODE_CAPS) begin
                        // Typematic repeats of caps lock arrive with caps_held set.
                        if (!caps_held) caps_on <= ~caps_on;
                        caps_held <= 1'b1;
                    end
                    if (lookup_hit) begin
                        ascii2   <= ascii1;
                        ascii1   <= lookup_ascii;
                        new_char <= 1'b1;
                    end
                end
                EV_BREAK: begin
                    if (byte_in == CODE_LSHIFT) lshift_held <= 1'b0;
                    if (byte_in == CODE_RSHIFT) rshift_held <= 1'b0;
                    if (byte_in == CODE_CAPS)   caps_held   <= 1'b0;
                end
                EV_NONE, EV_EXTENDED: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_ascii_tracker.sv
// Self-checking bench for key_ascii_tracker: directed key sequences plus
// randomized byte streams compared every cycle against a behavioural model.
module tb_key_ascii_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic [7:0] ascii1;
    logic [7:0] ascii2;
    logic       new_char;
    logic       shift_active;
    logic       caps_on;

    key_ascii_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .ascii1       (ascii1),
        .ascii2       (ascii2),
        .new_char     (new_char),
        .shift_active (shift_active),
        .caps_on      (caps_on)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int pulse_cnt;

    // Reference keyboard model: letters a..z and digits 0..9 in order.
    logic [7:0] letter_codes [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    bit         m_ext, m_brk;
    bit         m_lshift, m_rshift, m_caps, m_caps_held;
    logic [7:0] m_a1, m_a2;
    bit         m_new;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns the ASCII character for a make code, or -1 if unmapped.
    function automatic int char_of(input logic [7:0] code, input bit upper);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) return (upper ? 65 : 97) + i;
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) return 48 + i;
        if (code == 8'h29) return 32;
        if (code == 8'h5A) return 13;
        if (code == 8'h66) return 8;
        return -1;
    endfunction

    task automatic model_update(input bit r, input bit v, input logic [7:0] b);
        int c;
        m_new = 0;
        if (r) begin
            m_ext = 0; m_brk = 0; m_lshift = 0; m_rshift = 0;
            m_caps = 0; m_caps_held = 0; m_a1 = 8'h00; m_a2 = 8'h00;
        end else if (v) begin
            if (!m_ext && !m_brk && b == 8'hE0) begin
                m_ext = 1;
            end else if (!m_brk && b == 8'hF0) begin
                m_brk = 1;
            end else begin
                if (m_ext) begin
                    // extended events are ignored
                end else if (m_brk) begin
                    if (b == 8'h12) m_lshift = 0;
                    if (b == 8'h59) m_rshift = 0;
                    if (b == 8'h58) m_caps_held = 0;
                end else begin
                    c = char_of(b, (m_lshift || m_rshift) != m_caps);
                    if (b == 8'h12) m_lshift = 1;
                    if (b == 8'h59) m_rshift = 1;
                    if (b == 8'h58) begin
                        if (!m_caps_held) m_caps = !m_caps;
                        m_caps_held = 1;
                    end
                    if (c >= 0) begin
                        m_a2  = m_a1;
                        m_a1  = c[7:0];
                        m_new = 1;
                    end
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
    endtask

    // One clock cycle: drive on the falling edge, compare just after the rising edge.
    task automatic step(input bit r, input bit v, input logic [7:0] b);
        @(negedge clk);
        rst        = r;
        byte_valid = v;
        byte_in    = b;
        @(posedge clk);
        #1;
        model_update(r, v, b);
        check("ascii1", ascii1, m_a1);
        check("ascii2", ascii2, m_a2);
        check("new_char", {7'd0, new_char}, {7'd0, m_new});
        check("shift_active", {7'd0, shift_active}, {7'd0, (m_lshift || m_rshift)});
        check("caps_on", {7'd0, caps_on}, {7'd0, m_caps});
        if (new_char) pulse_cnt++;
    endtask

    task automatic send(input logic [7:0] b);
        step(0, 1, b);
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00);
        pulse_cnt = 0;
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] specials [3] = '{8'h29, 8'h5A, 8'h66};
        logic [7:0] mods [3]     = '{8'h12, 8'h59, 8'h58};
        unique case ($urandom_range(0, 9))
            0, 1, 2, 3: return letter_codes[$urandom_range(0, 25)];
            4:          return digit_codes[$urandom_range(0, 9)];
            5:          return specials[$urandom_range(0, 2)];
            6:          return mods[$urandom_range(0, 2)];
            7:          return 8'hE0;
            8:          return 8'hF0;
            default:    return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        pulse_cnt = 0;
        do_reset();
        do_reset();

        // Plain make, then its break.
        send(8'h1C);
        check("seq1_a1", ascii1, 8'h61);
        check("seq1_a2", ascii2, 8'h00);
        send(8'hF0); send(8'h1C); step(0, 0, 8'h1C);
        check("seq1_pulses", 8'(pulse_cnt), 8'd1);
        check("seq1_hold_a1", ascii1, 8'h61);

        // Shift held for one letter, released before the next.
        do_reset();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C);
        check("seq2_a1", ascii1, 8'h61);
        check("seq2_a2", ascii2, 8'h41);
        check("seq2_shift", {7'd0, shift_active}, 8'd0);

        // Caps lock typematic repeat toggles once; shift then cancels caps.
        do_reset();
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        send(8'h1C);
        check("seq3_caps", {7'd0, caps_on}, 8'd1);
        check("seq3_a1_upper", ascii1, 8'h41);
        send(8'h12); send(8'h1C);
        check("seq3_a1_lower", ascii1, 8'h61);

        // Extended enter make/break is ignored; plain enter maps to CR.
        do_reset();
        send(8'h1C);
        pulse_cnt = 0;
        send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
        check("seq4_no_pulse", 8'(pulse_cnt), 8'd0);
        check("seq4_hold_a1", ascii1, 8'h61);
        send(8'h5A);
        check("seq4_enter", ascii1, 8'h0D);

        // Reset mid-sequence discards the pending break prefix.
        do_reset();
        send(8'h12); send(8'h58); send(8'hF0);
        step(1, 1, 8'h1C);
        check("seq5_rst_a1", ascii1, 8'h00);
        check("seq5_rst_caps", {7'd0, caps_on}, 8'd0);
        check("seq5_rst_shift", {7'd0, shift_active}, 8'd0);
        send(8'h1C);
        check("seq5_a1", ascii1, 8'h61);

        // Back-to-back bytes on consecutive cycles.
        do_reset();
        send(8'h16); send(8'h1E); step(0, 0, 8'h00);
        check("seq6_a1", ascii1, 8'h32);
        check("seq6_a2", ascii2, 8'h31);
        check("seq6_pulses", 8'(pulse_cnt), 8'd2);

        // Randomized byte stream with idle gaps and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 4) != 0);
            step(r, v, pick_byte());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_ascii_tracker.md
KEY_ASCII_TRACKER -- requirements
Module: key_ascii_tracker

Interface
REQ-001 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 byte_valid  input  1  one-cycle strobe: byte_in holds a complete PS/2 scan-code byte.
REQ-005 byte_in  input  8  scan-code set 2 byte from the PS/2 receiver.
REQ-006 ascii1  output  8  most recent accepted character (ASCII), registered.
REQ-007 ascii2  output  8  previously accepted character (ASCII), registered.
REQ-008 new_char  output  1  one-cycle pulse, high in the cycle ascii1/ascii2 take new values.
REQ-009 shift_active  output  1  registered: either shift key currently held.
REQ-010 caps_on  output  1  registered caps-lock toggle state.

Function
REQ-011 The prefix FSM SHALL have the states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 then F0 seen), advancing only on byte_valid.
REQ-012 Transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte in any state completes a key event and returns to IDLE.
REQ-013 A completed event SHALL be classified as make (from IDLE), break (from BRK), extended make (from EXT) or extended break (from EXT_BRK).
REQ-014 Extended make and extended break events SHALL cause no output or flag change.
REQ-015 Left shift (0x12) and right shift (0x59) SHALL each have a held flag, set on make and cleared on break; shift_active = OR of the two flags.
REQ-016 Caps lock (0x58) make SHALL toggle caps_on only when a caps_held flag is clear, then set caps_held; caps break clears caps_held, so typematic repeats toggle at most once.
REQ-017 Make codes SHALL map as follows:
  - letters: lowercase 0x61-0x7A, or uppercase 0x41-0x5A when shift_active XOR caps_on.
  - digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> 0x30-0x39; shift has no effect on digits.
  - space 0x29 -> 0x20; enter 0x5A -> 0x0D; backspace 0x66 -> 0x08.
REQ-018 Each mapped make, including typematic repeats, SHALL shift the history in one cycle: ascii2<=ascii1, ascii1<=new code, new_char=1.
REQ-019 Latency: outputs SHALL update on the clock edge after the cycle where the final byte_valid is sampled.
REQ-020 Unmapped make codes (including 0xAA, 0xFA, 0xEE, 0xFE, 0xE1) and all break codes SHALL leave ascii1/ascii2 unchanged and new_char low.
REQ-021 Shift/caps state used for mapping SHALL be the value before the current byte.
REQ-022 byte_valid on back-to-back cycles SHALL be fully accepted with no byte dropped; byte_in is ignored when byte_valid is low.

Reset
REQ-023 When rst is high at a clock edge, the FSM SHALL go to IDLE, ascii1=ascii2=0x00, and new_char, shift_active, caps_on and all held flags SHALL be 0; rst SHALL override a coincident byte_valid.
REQ-024 A reset mid-sequence (after E0 or F0) SHALL discard the pending prefix.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the prefix constants (E0, F0), the modifier codes (0x12, 0x59, 0x58) and the special-key codes.
REQ-026 The scan-to-ASCII lookup SHALL be one combinational sub-module, scancode_to_ascii (inputs: code, upper; outputs: ascii, hit).

Verification
REQ-027 The bench SHALL cover:
  - 1C -> ascii1=0x61, ascii2=0x00, one new_char pulse; then F0,1C -> no change.
  - 12,1C,F0,1C,F0,12,1C -> ascii1=0x61, ascii2=0x41; shift_active ends 0.
  - 58,58,58,F0,58,1C -> caps_on=1, ascii1=0x41; then 12,1C -> ascii1=0x61.
  - E0,5A then E0,F0,5A -> no new_char, outputs unchanged; then 5A -> ascii1=0x0D.
  - F0, rst pulse, 1C -> ascii1=0x61, with all state zero immediately after reset.
  - Back-to-back bytes 16,1E on consecutive cycles -> ascii1=0x32, ascii2=0x31, two new_char pulses.
